toom8_pointwise: RTL and testbench
==================================

Name: toom8_pointwise

Overview:
- First arithmetic stage of the 1024x1024-bit Toom-8 multiplier.
- Splits each operand into eight 128-bit limbs, evaluates both limb polynomials at 15 points (0, ±1, ±2, ±3, ±4, ±5, ±6, +7, infinity) and multiplies the evaluations pointwise.
- Registers the 15 signed pointwise products for the downstream interpolation stage.
- Also registers the exact 2048-bit product X*Y. This is a golden output for interpolation checking.

Parameters:
- LIMB_W, 128, limb width in bits. Fixed; the port widths below assume 128.
- NLIMB, 8, limbs per operand. Fixed.

Ports:
- clk  in  1  sole clock; rising-edge.
- rst  in  1  reset, synchronous and active-high.
- X  in  1024  operand A, unsigned; limb a_i = X[128i+127:128i], with a0 the least significant.
- Y  in  1024  operand B, unsigned; limb b_i defined the same way.
- product  out  2048  registered exact X*Y, unsigned.
- p0  out  258 signed  A(0)*B(0) = a0*b0.
- p1, p2  out  264 signed each  products at x=+1 and x=-1.
- p3, p4  out  278 signed each  products at x=+2 and x=-2.
- p5, p6  out  288 signed each  products at x=+3 and x=-3.
- p7, p8  out  296 signed each  products at x=+4 and x=-4.
- p9, p10  out  298 signed each  products at x=+5 and x=-5.
- p11, p12  out  300 signed each  products at x=+6 and x=-6.
- p13  out  310 signed  product at x=+7.
- p14  out  258 signed  product at infinity, a7*b7.

Behaviour:
- Polynomial: A(x) = sum over i=0..7 of a_i*x^i; B(x) is defined the same way. For point k, pk = A(x_k)*B(x_k) in exact signed arithmetic.
- Evaluation at -x: even-index terms are added, odd-index terms are subtracted, so the result can be negative.
- Width rules:
  - Limbs are zero-extended to signed.
  - Evaluations are computed at full precision with no truncation.
  - Each product is sign-extended into its port width.
  - The port widths are guaranteed sufficient for all-ones inputs, so overflow is impossible.
- Latency 1 cycle: X and Y sampled on rising edge N drive all outputs immediately after edge N. p0..p14 and product update on the same edge.
- No handshake. The block is fully pipelined and accepts new operands every cycle.
- Reset: when rst=1 at a rising edge, all outputs become 0 on that edge, overriding the data path. The first valid result is the edge after rst deasserts.
- Reset asserted mid-stream discards any in-flight result.
- Implementation freedom: evaluations may use shift-add (constant multiplies by x^i). The multipliers may be inferred (*).

Decomposition:
- Shared package toom8_pkg holds:
  - LIMB_W and NLIMB.
  - The evaluation point constants.
  - Per-point evaluation and product widths (EVAL_W_k, PROD_W_k), so the interpolation stage can reuse them.
- Natural sub-module: toom8_eval. It takes eight limbs and a signed point constant, and outputs the signed evaluation. It is instantiated 14 times per operand (infinity needs no instance). The top level holds the multipliers and output registers.

Test Plan:
- Reset: hold rst=1 for 2 cycles with nonzero X/Y -> all outputs 0. Deassert rst with X=Y=0 -> all outputs remain 0.
- Small limbs, X=Y: a0=253, a1..a7=2..8 -> after 1 cycle p0=64009, p1=82944 (A(1)=288), p2=61504 (A(-1)=248), p3=4182025 (A(2)=2045), p14=64, product = X*X.
- Sign check: X with only a1=5, Y with only b0=3 -> p0=0, p1=15, p2=-15, p3=30, p4=-30, p13=105, p14=0, product = 15·2^128.
- Max operands: X=Y=all ones -> p1=(8·(2^128-1))^2, p13 positive and exact, product=(2^1024-1)^2; no sign flip on any output.
- Back-to-back: apply a new X/Y every cycle for 4 cycles -> each output set matches the inputs of the preceding edge, with no bubbles.
- Reset mid-stream: assert rst while operands are changing -> outputs 0 on that edge; a correct result appears 1 cycle after deassertion.

Source files
------------

// File: rtl/toom8_pkg.sv
// Shared constants for the Toom-8 multiplier: limb geometry, evaluation
// points and per-point evaluation/product widths.
package toom8_pkg;

    localparam int LIMB_W = 128;
    localparam int NLIMB  = 8;
    localparam int NPOINT = 15;

    // Index k matches output pk; entry 14 is the point at infinity (value unused).
    localparam int POINT_K [NPOINT] = '{0, 1, -1, 2, -2, 3, -3, 4, -4,
                                        5, -5, 6, -6, 7, 0};

    localparam int EVAL_W_K [NPOINT] = '{129, 132, 132, 139, 139, 144, 144,
                                         148, 148, 149, 149, 150, 150, 155, 129};

    localparam int PROD_W_K [NPOINT] = '{258, 264, 264, 278, 278, 288, 288,
                                         296, 296, 298, 298, 300, 300, 310, 258};

endpackage

// File: rtl/toom8_eval.sv
// Evaluates the 8-limb polynomial sum a_i * POINT^i as a signed value.
module toom8_eval
    import toom8_pkg::*;
#(
    parameter int EVAL_W = 132,
    parameter int POINT  = 1
) (
    input  logic [NLIMB*LIMB_W-1:0] i_limbs,
    output logic signed [EVAL_W-1:0] o_eval
);

    localparam logic signed [EVAL_W-1:0] PT = EVAL_W'(POINT);

    logic signed [EVAL_W-1:0] w_acc;

    // Horner form; partial sums never exceed the |POINT| evaluation, so EVAL_W holds them.
    always_comb begin
        w_acc = '0;
        for (int i = NLIMB - 1; i >= 0; i--) begin
            w_acc = w_acc * PT + EVAL_W'($signed({1'b0, i_limbs[i*LIMB_W +: LIMB_W]}));
        end
    end

    assign o_eval = w_acc;

endmodule

// File: rtl/toom8_pointwise.sv
// Toom-8 evaluation and pointwise multiply stage: 15 signed point products
// plus the exact 2048-bit product, all registered with 1-cycle latency.
module toom8_pointwise
    import toom8_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [1023:0]       X,
    input  logic [1023:0]       Y,
    output logic [2047:0]       product,
    output logic signed [257:0] p0,
    output logic signed [263:0] p1,
    output logic signed [263:0] p2,
    output logic signed [277:0] p3,
    output logic signed [277:0] p4,
    output logic signed [287:0] p5,
    output logic signed [287:0] p6,
    output logic signed [295:0] p7,
    output logic signed [295:0] p8,
    output logic signed [297:0] p9,
    output logic signed [297:0] p10,
    output logic signed [299:0] p11,
    output logic signed [299:0] p12,
    output logic signed [309:0] p13,
    output logic signed [257:0] p14
);

    logic [2047:0]       r_product;
    logic signed [257:0] r_p14;
    logic [2047:0]       w_product;
    logic signed [257:0] w_p14;

    assign w_product = {1024'b0, X} * {1024'b0, Y};
    assign w_p14     = {130'b0, X[1023:896]} * {130'b0, Y[1023:896]};

    for (genvar k = 0; k < NPOINT - 1; k++) begin : gen_pt
        localparam int EW = EVAL_W_K[k];
        localparam int PW = PROD_W_K[k];

        logic signed [EW-1:0] w_ea;
        logic signed [EW-1:0] w_eb;
        logic signed [PW-1:0] w_prod;
        logic signed [PW-1:0] r_prod;

        toom8_eval #(.EVAL_W(EW), .POINT(POINT_K[k])) u_eval_a (
            .i_limbs (X),
            .o_eval  (w_ea)
        );

        toom8_eval #(.EVAL_W(EW), .POINT(POINT_K[k])) u_eval_b (
            .i_limbs (Y),
            .o_eval  (w_eb)
        );

        assign w_prod = PW'(w_ea) * PW'(w_eb);

        // Point product register; reset forces zero over the data path.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_prod <= '0;
            end else begin
                r_prod <= w_prod;
            end
        end
    end

    // Infinity product and golden full product registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_product <= '0;
            r_p14     <= '0;
        end else begin
            r_product <= w_product;
            r_p14     <= w_p14;
        end
    end

    assign product = r_product;
    assign p0      = gen_pt[0].r_prod;
    assign p1      = gen_pt[1].r_prod;
    assign p2      = gen_pt[2].r_prod;
    assign p3      = gen_pt[3].r_prod;
    assign p4      = gen_pt[4].r_prod;
    assign p5      = gen_pt[5].r_prod;
    assign p6      = gen_pt[6].r_prod;
    assign p7      = gen_pt[7].r_prod;
    assign p8      = gen_pt[8].r_prod;
    assign p9      = gen_pt[9].r_prod;
    assign p10     = gen_pt[10].r_prod;
    assign p11     = gen_pt[11].r_prod;
    assign p12     = gen_pt[12].r_prod;
    assign p13     = gen_pt[13].r_prod;
    assign p14     = r_p14;

endmodule

// File: tb/tb_toom8_pointwise.sv
// Self-checking bench for toom8_pointwise: polynomial model checked every
// cycle plus directed literal expectations.
module tb_toom8_pointwise;

    localparam int PTS [14] = '{0, 1, -1, 2, -2, 3, -3, 4, -4, 5, -5, 6, -6, 7};

    logic                clk;
    logic                rst;
    logic [1023:0]       X;
    logic [1023:0]       Y;
    logic [2047:0]       product;
    logic signed [257:0] p0;
    logic signed [263:0] p1;
    logic signed [263:0] p2;
    logic signed [277:0] p3;
    logic signed [277:0] p4;
    logic signed [287:0] p5;
    logic signed [287:0] p6;
    logic signed [295:0] p7;
    logic signed [295:0] p8;
    logic signed [297:0] p9;
    logic signed [297:0] p10;
    logic signed [299:0] p11;
    logic signed [299:0] p12;
    logic signed [309:0] p13;
    logic signed [257:0] p14;

    int n_checks = 0;
    int n_fail   = 0;

    logic signed [639:0] dut_p [15];
    logic signed [639:0] exp_p [15];
    logic [2047:0]       exp_prod;
    logic                armed = 1'b0;

    toom8_pointwise dut (
        .clk(clk), .rst(rst), .X(X), .Y(Y), .product(product),
        .p0(p0), .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5), .p6(p6),
        .p7(p7), .p8(p8), .p9(p9), .p10(p10), .p11(p11), .p12(p12),
        .p13(p13), .p14(p14)
    );

    assign dut_p[0]  = 640'(p0);
    assign dut_p[1]  = 640'(p1);
    assign dut_p[2]  = 640'(p2);
    assign dut_p[3]  = 640'(p3);
    assign dut_p[4]  = 640'(p4);
    assign dut_p[5]  = 640'(p5);
    assign dut_p[6]  = 640'(p6);
    assign dut_p[7]  = 640'(p7);
    assign dut_p[8]  = 640'(p8);
    assign dut_p[9]  = 640'(p9);
    assign dut_p[10] = 640'(p10);
    assign dut_p[11] = 640'(p11);
    assign dut_p[12] = 640'(p12);
    assign dut_p[13] = 640'(p13);
    assign dut_p[14] = 640'(p14);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic signed [639:0] eval_at(input logic [1023:0] v, input int k);
        logic signed [639:0] s;
        logic signed [639:0] pw;
        s  = '0;
        pw = 640'sd1;
        for (int i = 0; i < 8; i++) begin
            s  = s + $signed({512'b0, v[i*128 +: 128]}) * pw;
            pw = pw * 640'(k);
        end
        return s;
    endfunction

    task automatic chk(input string nm, input logic signed [639:0] got,
                       input logic signed [639:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, got, want);
        end
    endtask

    task automatic chk_prod(input string nm, input logic [2047:0] want);
        int first_bad;
        n_checks++;
        if (product !== want) begin
            n_fail++;
            first_bad = -1;
            for (int i = 2047; i >= 0; i--) begin
                if (product[i] !== want[i]) first_bad = i;
            end
            $display("FAIL %s: got[63:0] %h required[63:0] %h first differing bit %0d",
                     nm, product[63:0], want[63:0], first_bad);
        end
    endtask

    task automatic step(input logic [1023:0] x, input logic [1023:0] y, input logic r);
        @(negedge clk);
        X   = x;
        Y   = y;
        rst = r;
    endtask

    // Reference model: products of the inputs seen at each rising edge.
    always @(posedge clk) begin
        for (int k = 0; k < 14; k++) begin
            exp_p[k] <= rst ? '0 : eval_at(X, PTS[k]) * eval_at(Y, PTS[k]);
        end
        exp_p[14] <= rst ? '0 : $signed({512'b0, X[1023:896]}) * $signed({512'b0, Y[1023:896]});
        exp_prod  <= rst ? '0 : {1024'b0, X} * {1024'b0, Y};
        armed     <= 1'b1;
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (armed) begin
            for (int k = 0; k < 15; k++) begin
                chk($sformatf("model_p%0d", k), dut_p[k], exp_p[k]);
            end
            chk_prod("model_product", exp_prod);
        end
    end

    logic [1023:0] xs;
    logic [1023:0] xa;
    logic [1023:0] yb;
    logic [1023:0] ones;
    logic [1023:0] v6;
    logic signed [639:0] m8;
    logic [2047:0] w_max;

    initial begin
        rst = 1'b1;
        X   = {32{32'h1234_5677}};
        Y   = {16{64'hfedc_ba98_7654_3210}};

        step({32{32'h8765_4321}}, {32{32'h0f0f_f0f0}}, 1'b1);
        step({32{32'hdead_beef}}, {32{32'h0bad_cafe}}, 1'b1);
        @(negedge clk);
        chk("rst_p1", dut_p[1], 640'sd0);
        chk("rst_p13", dut_p[13], 640'sd0);
        chk_prod("rst_product", 2048'd0);

        step('0, '0, 1'b0);
        @(negedge clk);
        chk("zero_p7", dut_p[7], 640'sd0);
        chk_prod("zero_product", 2048'd0);

        xs = '0;
        xs[127:0] = 128'd253;
        for (int i = 1; i < 8; i++) xs[i*128 +: 128] = 128'(i + 1);
        step(xs, xs, 1'b0);
        @(negedge clk);
        chk("small_p0", dut_p[0], 640'sd64009);
        chk("small_p1", dut_p[1], 640'sd82944);
        chk("small_p2", dut_p[2], 640'sd61504);
        chk("small_p3", dut_p[3], 640'sd4182025);
        chk("small_p14", dut_p[14], 640'sd64);
        chk_prod("small_product", {1024'b0, xs} * {1024'b0, xs});

        xa = '0;
        xa[255:128] = 128'd5;
        yb = '0;
        yb[127:0] = 128'd3;
        step(xa, yb, 1'b0);
        @(negedge clk);
        chk("sign_p0", dut_p[0], 640'sd0);
        chk("sign_p1", dut_p[1], 640'sd15);
        chk("sign_p2", dut_p[2], -640'sd15);
        chk("sign_p3", dut_p[3], 640'sd30);
        chk("sign_p4", dut_p[4], -640'sd30);
        chk("sign_p13", dut_p[13], 640'sd105);
        chk("sign_p14", dut_p[14], 640'sd0);
        chk_prod("sign_product", 2048'd15 << 128);

        ones = '1;
        m8 = ((640'sd1 <<< 128) - 640'sd1) * 640'sd8;
        w_max = {2048{1'b1}} - (2048'd1 << 1025) + 2048'd2;
        step(ones, ones, 1'b0);
        @(negedge clk);
        chk("max_p1", dut_p[1], m8 * m8);
        chk("max_p2", dut_p[2], 640'sd0);
        chk("max_p13_sign", 640'(p13[309]), 640'sd0);
        chk("max_p11_sign", 640'(p11[299]), 640'sd0);
        chk_prod("max_product", w_max);

        step({16{64'h0123_4567_89ab_cdef}}, {32{32'h8000_0001}}, 1'b0);
        step({8{128'h1}}, {8{128'hffff_0000_ffff_0000_ffff_0000_ffff_0000}}, 1'b0);
        step({4{256'h0}} | {16{64'haaaa_5555_aaaa_5555}}, ones, 1'b0);
        step(ones, xs, 1'b0);

        v6 = {32{32'h3c3c_c3c3}};
        step({32{32'h7777_1111}}, {32{32'h2222_9999}}, 1'b1);
        step(v6, xa, 1'b0);
        @(negedge clk);
        chk_prod("post_rst_product", {1024'b0, v6} * {1024'b0, xa});
        chk("post_rst_p14", dut_p[14], 640'sd0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
